// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl: load-use stall, EX forwarding selects and redirect flush sequencing for a 5-stage RV32I pipe
module rv32i_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [31:0]      id_iw,
   input  logic             ex_redirect,
   output logic             stall_out,
   output logic             flush_out,
   output logic             ex_bubble,
   output logic [1:0]       fwd_rs1_sel,
   output logic [1:0]       fwd_rs2_sel,
   output logic [CNT_W-1:0] hz_cnt
);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
   } sb_t;
   typedef enum logic {RUN, FLUSH} state_t;
   state_t     state;
   logic [2:0] fl_cnt;
   sb_t        sb_ex, sb_mem, sb_wb, id_ent;
   logic [6:0] op;
   logic [4:0] rs1, rs2;
   logic       use_rs1, use_rs2, issue, lu_hit;
   logic [1:0] sel1, sel2;
   logic       unused_ok;
   assign op  = id_iw[6:0];
   assign rs1 = id_iw[19:15];
   assign rs2 = id_iw[24:20];
   // the WB entry and the MEM load flag are tracked for completeness but no select depends on them
   assign unused_ok = ^{id_iw[31:25], id_iw[14:12], sb_wb, sb_mem.is_load};
   // decode register usage of the ID instruction; unknown opcodes touch nothing
   always_comb begin
      use_rs1 = op inside {OP_R, OP_IALU, OP_LOAD, OP_S, OP_B, OP_JALR};
      use_rs2 = op inside {OP_R, OP_S, OP_B};
      id_ent.valid   = (op inside {OP_R, OP_IALU, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}) && id_iw[11:7] != 5'd0;
      id_ent.rd      = id_iw[11:7];
      id_ent.is_load = op == OP_LOAD;
   end
   // hazard detection, flush request and forwarding selects seen by the issuing instruction
   always_comb begin
      lu_hit    = sb_ex.valid && sb_ex.is_load && ((use_rs1 && rs1 == sb_ex.rd) || (use_rs2 && rs2 == sb_ex.rd));
      flush_out = state == FLUSH || ex_redirect;
      stall_out = state == RUN && !ex_redirect && id_valid && lu_hit;
      issue     = state == RUN && !ex_redirect && id_valid && !stall_out;
      sel1 = !use_rs1 ? 2'b00 :
             (sb_ex.valid && !sb_ex.is_load && sb_ex.rd == rs1) ? 2'b01 :
             (sb_mem.valid && sb_mem.rd == rs1) ? 2'b10 : 2'b00;
      sel2 = !use_rs2 ? 2'b00 :
             (sb_ex.valid && !sb_ex.is_load && sb_ex.rd == rs2) ? 2'b01 :
             (sb_mem.valid && sb_mem.rd == rs2) ? 2'b10 : 2'b00;
   end
   // shift the shadow scoreboard and register the EX-stage controls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sb_ex       <= '0;
         sb_mem      <= '0;
         sb_wb       <= '0;
         ex_bubble   <= 1'b1;
         fwd_rs1_sel <= 2'b00;
         fwd_rs2_sel <= 2'b00;
      end else begin
         sb_wb       <= sb_mem;
         sb_mem      <= sb_ex;
         sb_ex       <= issue ? id_ent : '0;
         ex_bubble   <= !issue;
         fwd_rs1_sel <= issue ? sel1 : 2'b00;
         fwd_rs2_sel <= issue ? sel2 : 2'b00;
      end
   end
   // redirect flush sequencer; the redirect cycle itself is the first flush cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= RUN;
         fl_cnt <= 3'd0;
      end else if (state == RUN) begin
         if (ex_redirect) begin
            state  <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
            fl_cnt <= 3'(FLUSH_CYCLES - 1);
         end
      end else begin
         fl_cnt <= fl_cnt - 3'd1;
         if (fl_cnt <= 3'd1) state <= RUN;
      end
   end
   // saturating count of stall and flush cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) hz_cnt <= '0;
      else if ((stall_out || flush_out) && hz_cnt != '1) hz_cnt <= hz_cnt + 1'b1;
   end
endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// tb_rv32i_hazard_ctrl: scoreboard-driven checks of stall, flush, forwarding and counter behaviour
module tb_rv32i_hazard_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        id_valid = 1'b0;
   logic [31:0] id_iw = 32'd0;
   logic        ex_redirect = 1'b0;
   logic        stall_out, flush_out, ex_bubble;
   logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
   logic [15:0] hz_cnt;
   int          n_chk = 0;
   int          n_fail = 0;
   int          exp_hz = 0;
   typedef struct {
      logic       bub;
      logic [1:0] s1;
      logic [1:0] s2;
   } exp_t;
   exp_t        q[$];

   rv32i_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_iw(id_iw), .ex_redirect(ex_redirect),
      .stall_out(stall_out), .flush_out(flush_out), .ex_bubble(ex_bubble),
      .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .hz_cnt(hz_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] sub(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   // one pipeline cycle: retire the previous cycle's expectation, drive, check combinational outputs, queue the registered ones
   task automatic step(input string nm, input logic v, input logic [31:0] iw, input logic red,
                       input logic e_st, input logic e_fl, input logic e_bub, input logic [1:0] e1, input logic [1:0] e2);
      exp_t e;
      @(negedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         n_chk++;
         if (ex_bubble !== e.bub) begin n_fail++; $display("FAIL %s ex_bubble got %b exp %b", nm, ex_bubble, e.bub); end
         n_chk++;
         if (fwd_rs1_sel !== e.s1) begin n_fail++; $display("FAIL %s fwd_rs1_sel got %b exp %b", nm, fwd_rs1_sel, e.s1); end
         n_chk++;
         if (fwd_rs2_sel !== e.s2) begin n_fail++; $display("FAIL %s fwd_rs2_sel got %b exp %b", nm, fwd_rs2_sel, e.s2); end
      end
      id_valid = v; id_iw = iw; ex_redirect = red;
      #1;
      n_chk++;
      if (stall_out !== e_st) begin n_fail++; $display("FAIL %s stall_out got %b exp %b", nm, stall_out, e_st); end
      n_chk++;
      if (flush_out !== e_fl) begin n_fail++; $display("FAIL %s flush_out got %b exp %b", nm, flush_out, e_fl); end
      q.push_back('{e_bub, e1, e2});
      if (e_st || e_fl) exp_hz++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step("idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
   endtask

   task automatic check_hz(input string nm);
      n_chk++;
      if (hz_cnt !== 16'(exp_hz)) begin n_fail++; $display("FAIL %s hz_cnt got %0d exp %0d", nm, hz_cnt, exp_hz); end
   endtask

   task automatic test_reset();
      id_valid = 1'b1; id_iw = lw(5'd1, 5'd0, 12'd0);
      repeat (2) @(posedge clk);
      #2;
      n_chk++;
      if ({stall_out, flush_out, ex_bubble, fwd_rs1_sel, fwd_rs2_sel} !== 7'b0010000)
         begin n_fail++; $display("FAIL reset outputs got %b exp 0010000", {stall_out, flush_out, ex_bubble, fwd_rs1_sel, fwd_rs2_sel}); end
      n_chk++;
      if (hz_cnt !== 16'd0) begin n_fail++; $display("FAIL reset hz_cnt got %0d exp 0", hz_cnt); end
      @(negedge clk);
      id_valid = 1'b0; reset = 1'b1;
   endtask

   task automatic test_forward();
      idle(3);
      step("fwd_addi", 1'b1, addi(5'd1, 5'd0, 12'd5), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("fwd_add",  1'b1, add(5'd2, 5'd1, 5'd1),   1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
      idle(1);
   endtask

   task automatic test_load_use();
      idle(3);
      step("lu_lw",    1'b1, lw(5'd3, 5'd1, 12'd0),  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("lu_stall", 1'b1, add(5'd4, 5'd3, 5'd2),  1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
      step("lu_add",   1'b1, add(5'd4, 5'd3, 5'd2),  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
      idle(1);
      check_hz("lu_hz");
   endtask

   task automatic test_back_to_back();
      idle(3);
      step("b2b_addi", 1'b1, addi(5'd5, 5'd0, 12'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("b2b_nop",  1'b1, addi(5'd0, 5'd0, 12'd0), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("b2b_sub",  1'b1, sub(5'd6, 5'd5, 5'd0),   1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
      step("x0_addi",  1'b1, addi(5'd0, 5'd0, 12'd1), 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("x0_add",   1'b1, add(5'd7, 5'd0, 5'd0),   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("rs2_add",  1'b1, add(5'd8, 5'd0, 5'd7),   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
      idle(1);
   endtask

   task automatic test_redirect();
      idle(3);
      step("rd_pulse", 1'b1, addi(5'd1, 5'd0, 12'd1), 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
      step("rd_again", 1'b1, addi(5'd1, 5'd0, 12'd1), 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
      step("rd_run",   1'b1, add(5'd2, 5'd1, 5'd0),   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      idle(1);
      check_hz("rd_hz");
   endtask

   task automatic test_redirect_load_use();
      idle(3);
      step("rl_lw",    1'b1, lw(5'd3, 5'd0, 12'd4),  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
      step("rl_both",  1'b1, add(5'd4, 5'd3, 5'd3),  1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
      step("rl_flush", 1'b1, add(5'd4, 5'd3, 5'd3),  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
      idle(2);
      check_hz("rl_hz");
   endtask

   task automatic test_reset_flush();
      idle(2);
      step("rf_pulse", 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
      ex_redirect = 1'b0;
      #2 reset = 1'b0;
      #1;
      n_chk++;
      if (flush_out !== 1'b0) begin n_fail++; $display("FAIL rf_async flush_out got %b exp 0", flush_out); end
      n_chk++;
      if (hz_cnt !== 16'd0) begin n_fail++; $display("FAIL rf_async hz_cnt got %0d exp 0", hz_cnt); end
      q.delete();
      exp_hz = 0;
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      check_hz("rf_hz");
   endtask

   task automatic test_saturate();
      idle(1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      for (int i = 0; i < 65539; i++) begin
         @(negedge clk);
         if (i == 65534) begin
            n_chk++;
            if (hz_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre hz_cnt got %h exp fffe", hz_cnt); end
         end
         ex_redirect = (i % 2 == 0);
      end
      @(negedge clk);
      ex_redirect = 1'b0;
      n_chk++;
      if (hz_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold hz_cnt got %h exp ffff", hz_cnt); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_back_to_back();
      test_redirect();
      test_redirect_load_use();
      test_reset_flush();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
